md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the execute stage of the 5-stage MIPS pipeline.
- Consumes the two operands read out of the register file (after forwarding) and keeps the architectural HI/LO registers.
- Presents Busy to the hazard unit. The hazard unit stalls the decode stage on any MDU instruction, or any mfhi/mflo, while Busy or Start is high.

Parameters:
- MULT_CYCLES, 5, execute latency of mult/multu (and madd family) in cycles, >=1.
- DIV_CYCLES, 10, execute latency of div/divu in cycles, >=1.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request; Op/A/B are valid this cycle.
- Op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; other codes are no-op.
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  32  operand rt (divisor / multiplier).
- Busy  output  1  long operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; no partial HI/LO write.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, down-counter loaded with latency).
- IDLE with Start and Op in {0,1,2,3,6..9}:
  - At edge t0, latch A/B/Op, compute the result into pending regs, load counter = N, go to RUN.
  - N = MULT_CYCLES for mul-type ops, DIV_CYCLES for div-type ops.
- RUN:
  - Counter decrements every edge.
  - At the edge where the counter goes 1->0: commit pending to HI/LO, return to IDLE.
  - Busy is high for exactly N cycles after t0. HI/LO hold their old values during RUN.
- MTHI/MTLO in IDLE: HI<=A (resp. LO<=A) at edge t0. Busy stays 0. Visible next cycle.
- Start while Busy=1: ignored entirely; no state change. This is a hazard-unit bug case, but it must be deterministic.
- Unused Op codes with Start: ignored, no Busy.
- MULT: {HI,LO} = signed(A)*signed(B), 64-bit two's complement.
- MULTU: unsigned 64-bit product.
- DIV:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B=0): full DIV_CYCLES latency still applies; HI/LO are left unchanged at commit.
- Start in the same cycle that RUN completes: Busy is still 1 that cycle, so Start is ignored.
- No combinational path from Start/Op/A/B to Busy/HI/LO. All outputs are registered.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Ops 6-9 are legal with MULT_CYCLES latency.
  - MADD: {HI,LO} += signed product. MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product. MSUBU: {HI,LO} -= unsigned product.
  - All arithmetic is modulo 2^64.
  - The accumulate base is the {HI,LO} value at commit, which equals the value at t0 because HI/LO are frozen while Busy.
- Undefined: Ops 6-9 are treated as unused codes (ignored, Busy stays 0), and no 64-bit adder is synthesised.

Test Plan:
- Reset then MULT A=0xFFFFFFFE(-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy=0.
- DIV A=0xFFFFFFF9(-7), B=2 -> after 10 cycles LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678, then the next cycle MTLO A=0xCAFEBABE -> HI=0x12345678, LO=0xCAFEBABE; Busy never asserts.
- DIVU B=0 with HI=0x11, LO=0x22 -> Busy 10 cycles; HI/LO still 0x11/0x22. Then MULT Start while Busy -> ignored; result unaffected.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with Reset asserted on the 3rd Busy cycle -> next cycle Busy=0, HI=LO=0, and no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0. Without the macro the same stimulus leaves HI/LO unchanged and Busy=0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the execute stage of the 5-stage MIPS pipeline.
//
// Holds the architectural HI/LO registers. A long operation (mult/div family)
// is accepted only while idle: its result is computed at the accepting edge into
// pending registers. It is committed to HI/LO when the latency counter expires.
// MTHI/MTLO write HI/LO directly while idle.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 6-9).
// Without it those codes are ignored and no 64-bit accumulator is built.
//
// Ports:
//   Clk    - clock, rising edge
//   Reset  - synchronous, active-high reset
//   Start  - one-cycle request; Op/A/B valid in the same cycle
//   Op     - operation code (0 MULT .. 9 MSUBU)
//   A      - rs operand (dividend / multiplicand / mthi-mtlo source)
//   B      - rt operand (divisor / multiplier)
//   Busy   - long operation in flight
//   HI, LO - architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pendHi_q, pendHi_d;
    logic [31:0]   pendLo_q, pendLo_d;
    logic          pendWr_q, pendWr_d;

    // Shared multiplier: operands are sign- or zero-extended to 64 bits so that the
    // low 64 bits of the product are correct for both signed and unsigned forms.
    logic        mulSigned;
    logic [63:0] mulA, mulB, product;

    always_comb begin
        mulSigned = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
        mulA      = mulSigned ? {{32{A[31]}}, A} : {32'd0, A};
        mulB      = mulSigned ? {{32{B[31]}}, B} : {32'd0, B};
        product   = mulA * mulB;
    end

    // Divider works on magnitudes, then restores signs: quotient truncates toward
    // zero, remainder takes the dividend's sign. This also yields 0x80000000 for
    // 0x80000000 / -1 without relying on signed-overflow behaviour. A zero divisor
    // is replaced by 1 only to keep the datapath defined; that result is discarded.
    logic        divSigned;
    logic [31:0] absA, absB, divisor, uQuot, uRem, divQuot, divRem;

    always_comb begin
        divSigned = (Op == OP_DIV);
        absA      = (divSigned && A[31]) ? (~A + 32'd1) : A;
        absB      = (divSigned && B[31]) ? (~B + 32'd1) : B;
        divisor   = (B == 32'd0) ? 32'd1 : absB;
        uQuot     = absA / divisor;
        uRem      = absA % divisor;
        divQuot   = (divSigned && (A[31] ^ B[31])) ? (~uQuot + 32'd1) : uQuot;
        divRem    = (divSigned && A[31]) ? (~uRem + 32'd1) : uRem;
    end

`ifdef MDU_MADD_EN
    // Accumulate base is the current HI/LO; it cannot change before commit since
    // HI/LO are frozen while busy.
    logic [63:0] accSum;

    always_comb begin
        if ((Op == OP_MSUB) || (Op == OP_MSUBU)) begin
            accSum = {hi_q, lo_q} - product;
        end else begin
            accSum = {hi_q, lo_q} + product;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pendHi_q <= '0;
            pendLo_q <= '0;
            pendWr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pendHi_q <= pendHi_d;
            pendLo_q <= pendLo_d;
            pendWr_q <= pendWr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pendHi_d = pendHi_q;
        pendLo_d = pendLo_q;
        pendWr_d = pendWr_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            pendHi_d = product[63:32];
                            pendLo_d = product[31:0];
                            pendWr_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pendHi_d = divRem;
                            pendLo_d = divQuot;
                            pendWr_d = (B != 32'd0);
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            pendHi_d = accSum[63:32];
                            pendLo_d = accSum[31:0];
                            pendWr_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (pendWr_q) begin
                        hi_d = pendHi_q;
                        lo_d = pendLo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Stimulus pushes expected (cycle, Busy, HI, LO) snapshots and expected Busy run
// lengths; a monitor on the falling clock edge pops and compares them.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          due;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t expQ[$];
    int   lenQ[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   runLen = 0;
    logic [31:0] curHi = 32'd0;
    logic [31:0] curLo = 32'd0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: snapshot checks at their due cycle, and Busy run length on each fall.
    always @(negedge Clk) begin
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].due <= cyc) begin
                if (expQ[i].due < cyc) begin
                    checkOutput({expQ[i].name, " stale"}, 32'(cyc), 32'(expQ[i].due));
                end else begin
                    checkOutput({expQ[i].name, " Busy"}, {31'd0, Busy}, {31'd0, expQ[i].busy});
                    checkOutput({expQ[i].name, " HI"}, HI, expQ[i].hi);
                    checkOutput({expQ[i].name, " LO"}, LO, expQ[i].lo);
                end
                expQ.delete(i);
            end
        end
        if (Busy === 1'b1) begin
            runLen++;
        end else if (runLen > 0) begin
            if (lenQ.size() == 0) begin
                checkOutput("unexpected Busy run", 32'(runLen), 32'd0);
            end else begin
                checkOutput("Busy length", 32'(runLen), 32'(lenQ.pop_front()));
            end
            runLen = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Drives one Start pulse; returns #1 after the edge that samples it.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        idle(1);
        Start = 1'b0;
    endtask

    task automatic expectAt(input string name, input int due, input logic busy,
                            input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.name = name;
        e.due  = due;
        e.busy = busy;
        e.hi   = hi;
        e.lo   = lo;
        expQ.push_back(e);
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] nHi, input logic [31:0] nLo);
        applyStimulus(op, a, b);
        expectAt({name, " running"}, cyc + n - 1, 1'b1, curHi, curLo);
        expectAt(name, cyc + n, 1'b0, nHi, nLo);
        lenQ.push_back(n);
        curHi = nHi;
        curLo = nLo;
        idle(n + 1);
    endtask

    task automatic moveTo(input string name, input logic hiSel, input logic [31:0] a);
        applyStimulus(hiSel ? 4'd4 : 4'd5, a, 32'd0);
        if (hiSel) curHi = a;
        else       curLo = a;
        expectAt(name, cyc, 1'b0, curHi, curLo);
    endtask

    int c;

    initial begin
        idle(3);
        Reset = 1'b0;
        expectAt("reset", cyc, 1'b0, 32'd0, 32'd0);
        idle(1);

        runOp("mult -2*3", 4'd0, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
        runOp("mult max*min", 4'd0, 32'h7FFFFFFF, 32'h80000000, MC, 32'hC0000000, 32'h80000000);
        runOp("div -7/2", 4'd2, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu", 4'd3, 32'hFFFFFFF9, 32'd2, DC, 32'd1, 32'h7FFFFFFC);
        runOp("multu", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'hFFFFFFFE, 32'h00000001);
        runOp("div overflow", 4'd2, 32'h80000000, 32'hFFFFFFFF, DC, 32'd0, 32'h80000000);

        moveTo("mthi", 1'b1, 32'h12345678);
        moveTo("mtlo", 1'b0, 32'hCAFEBABE);
        idle(1);

        applyStimulus(4'd10, 32'h5, 32'h6);
        expectAt("unused op", cyc, 1'b0, curHi, curLo);
        expectAt("unused op later", cyc + 2, 1'b0, curHi, curLo);
        idle(3);

        // Divide by zero, with Start pulses mid-run and on the completing cycle.
        moveTo("mthi 11", 1'b1, 32'h11);
        moveTo("mtlo 22", 1'b0, 32'h22);
        applyStimulus(4'd3, 32'd5, 32'd0);
        c = cyc;
        expectAt("divu by 0 running", c + DC - 1, 1'b1, 32'h11, 32'h22);
        expectAt("divu by 0", c + DC, 1'b0, 32'h11, 32'h22);
        expectAt("start at completion ignored", c + DC + 1, 1'b0, 32'h11, 32'h22);
        expectAt("start at completion ignored later", c + DC + 2, 1'b0, 32'h11, 32'h22);
        lenQ.push_back(DC);
        idle(2);
        applyStimulus(4'd0, 32'd7, 32'd7);
        idle(DC - 4);
        applyStimulus(4'd0, 32'd9, 32'd9);
        idle(MC + 2);

        // Reset on the third busy cycle aborts the multiply.
        applyStimulus(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        c = cyc;
        idle(2);
        expectAt("abort running", c + 2, 1'b1, 32'h11, 32'h22);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        expectAt("abort reset", c + 3, 1'b0, 32'd0, 32'd0);
        expectAt("abort no commit", c + MC, 1'b0, 32'd0, 32'd0);
        expectAt("abort no commit later", c + MC + 1, 1'b0, 32'd0, 32'd0);
        lenQ.push_back(3);
        curHi = 32'd0;
        curLo = 32'd0;
        idle(MC + 2);

        moveTo("mthi 0", 1'b1, 32'd0);
        moveTo("mtlo ffffffff", 1'b0, 32'hFFFFFFFF);
        idle(1);
`ifdef MDU_MADD_EN
        runOp("maddu", 4'd7, 32'd1, 32'd1, MC, 32'd1, 32'd0);
        runOp("msub", 4'd8, 32'd2, 32'd3, MC, 32'd0, 32'hFFFFFFFA);
`else
        applyStimulus(4'd7, 32'd1, 32'd1);
        expectAt("maddu disabled", cyc, 1'b0, 32'd0, 32'hFFFFFFFF);
        expectAt("maddu disabled later", cyc + MC, 1'b0, 32'd0, 32'hFFFFFFFF);
        idle(MC + 2);
`endif

        idle(3);
        checkOutput("pending snapshots", 32'(expQ.size()), 32'd0);
        checkOutput("pending Busy runs", 32'(lenQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
